mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Purpose: external-memory side of the CPU datapath. Takes one address-bus/data-bus transfer request from the core, runs a single memory cycle with a ready handshake, and latches read data into the Data Latch (DL).

Interface
REQ-001 The clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 CLK  input  1  single clock, all state changes on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 REQ  input  1  core transfer request, sampled only in IDLE.
REQ-005 WE  input  1  1 = write cycle, 0 = read cycle; captured with REQ.
REQ-006 ADDR_H  input  8  address high byte (ABH), captured with REQ.
REQ-007 ADDR_L  input  8  address low byte (ABL), captured with REQ.
REQ-008 WDATA  input  8  write data (Data Output Register source), captured with REQ.
REQ-009 MEM_DIN  input  8  read data from memory.
REQ-010 MEM_READY  input  1  memory completes the cycle this edge.
REQ-011 MEM_ADDR  output  16  registered address {ADDR_H, ADDR_L}.
REQ-012 MEM_DOUT  output  8  registered write data.
REQ-013 MEM_RW  output  1  1 = read, 0 = write (6502 R/W polarity).
REQ-014 MEM_VALID  output  1  cycle in progress toward memory.
REQ-015 RDATA  output  8  Data Latch contents.
REQ-016 BUSY  output  1  high in every state except IDLE.
REQ-017 DONE  output  1  one-cycle completion pulse.
REQ-018 ERR  output  1  qualifies DONE, high when the cycle ended by timeout.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ACCESS, FINISH.
REQ-020 In IDLE with REQ=1 at an edge, the block SHALL capture ADDR_H/ADDR_L/WDATA/WE, drive MEM_ADDR/MEM_DOUT, set MEM_RW=~WE and MEM_VALID=1, clear the wait counter, and enter ACCESS.
REQ-021 In IDLE with REQ=0, all outputs SHALL hold, MEM_VALID=0 and DONE=0.
REQ-022 In ACCESS, MEM_ADDR, MEM_DOUT and MEM_RW SHALL stay stable, and MEM_VALID SHALL stay 1.
REQ-023 In ACCESS with MEM_READY=1 at an edge: on a read, DL SHALL load MEM_DIN; on a write, DL SHALL be unchanged; then ERR<=0, DONE<=1, MEM_VALID<=0, and the state SHALL go to FINISH.
REQ-024 In ACCESS with MEM_READY=0, a 4-bit wait counter SHALL increment.
REQ-025 If MEM_READY=0 at the edge where the counter equals 15, the block SHALL abort: DL unchanged, ERR<=1, DONE<=1, MEM_VALID<=0, next state FINISH.
REQ-026 A MEM_READY=1 on the same edge as counter=15 SHALL complete normally, with no error.
REQ-027 In FINISH, DONE SHALL be high for exactly one cycle; the next edge SHALL clear DONE, return to IDLE and clear BUSY.
REQ-028 ERR SHALL hold until the next accepted request clears it.
REQ-029 REQ asserted in ACCESS or FINISH SHALL be ignored; the core must still hold REQ in IDLE for it to be accepted.
REQ-030 MEM_READY SHALL be ignored outside ACCESS.
REQ-031 Minimum latency SHALL be 2 cycles: REQ accepted at edge k, MEM_READY high at edge k+1, DONE high between edge k+1 and k+2, IDLE after edge k+2.
REQ-032 Back-to-back throughput SHALL be 1 transfer per 3 cycles at zero wait states.
REQ-033 After MEM_VALID falls, MEM_ADDR and MEM_DOUT SHALL hold their last values.
REQ-034 RDATA SHALL always equal DL, which is updated only by a successful read.

Reset
REQ-035 On RST=1, the block SHALL go immediately, without a clock, to state IDLE.
REQ-036 During reset the outputs SHALL be: MEM_ADDR=16'h0000, MEM_DOUT=8'h00, MEM_RW=1, MEM_VALID=0, RDATA=8'h00, BUSY=0, DONE=0, ERR=0, wait counter=0.
REQ-037 Reset asserted during ACCESS or FINISH SHALL abort the cycle with no DONE pulse.
REQ-038 After RST deasserts, the first REQ SHALL be accepted at the next edge.

Verification
REQ-039 Zero-wait read: REQ=1, WE=0, ADDR=16'h12F0, MEM_READY=1 at the next edge with MEM_DIN=8'hA5 -> MEM_RW=1, DONE pulses 2 cycles after REQ with ERR=0, RDATA=8'hA5.
REQ-040 Write with 3 wait states: WE=1, ADDR=16'h01FF, WDATA=8'h3C, MEM_READY low for 3 edges -> MEM_RW=0, MEM_DOUT=8'h3C stable for 4 cycles, DONE at cycle 5, RDATA unchanged.
REQ-041 Timeout: read, MEM_READY never high -> DONE=1, ERR=1 after 16 ACCESS edges; RDATA keeps its prior value; the next request clears ERR.
REQ-042 Boundary: MEM_READY=1 exactly on the 16th ACCESS edge -> ERR=0 and DL loaded.
REQ-043 REQ held continuously with MEM_READY=1 -> accepts occur every 3 cycles, and REQ changes during ACCESS/FINISH have no effect.
REQ-044 RST pulsed mid-ACCESS -> MEM_VALID=0 and BUSY=0 immediately, no DONE, RDATA=8'h00.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// External-memory bus controller: accepts one core transfer in IDLE, drives a
// single memory cycle with a ready handshake and a 16-edge timeout, and keeps
// read data in the Data Latch (DL), which is exposed on RDATA.
module mem_bus_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic [7:0]  ADDR_H,
    input  logic [7:0]  ADDR_L,
    input  logic [7:0]  WDATA,
    input  logic [7:0]  MEM_DIN,
    input  logic        MEM_READY,
    output logic [15:0] MEM_ADDR,
    output logic [7:0]  MEM_DOUT,
    output logic        MEM_RW,
    output logic        MEM_VALID,
    output logic [7:0]  RDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic [7:0] dl;

    assign RDATA = dl;

    // Transfer FSM; every bus-facing output is a register updated here.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            dl        <= '0;
            MEM_ADDR  <= '0;
            MEM_DOUT  <= '0;
            MEM_RW    <= 1'b1;
            MEM_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (REQ) begin
                        MEM_ADDR  <= {ADDR_H, ADDR_L};
                        MEM_DOUT  <= WDATA;
                        MEM_RW    <= ~WE;
                        MEM_VALID <= 1'b1;
                        BUSY      <= 1'b1;
                        ERR       <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= ACCESS;
                    end else begin
                        MEM_VALID <= 1'b0;
                    end
                end
                ACCESS: begin
                    // Ready wins over timeout when both land on the last wait edge.
                    if (MEM_READY) begin
                        if (MEM_RW) begin
                            dl <= MEM_DIN;
                        end
                        ERR       <= 1'b0;
                        DONE      <= 1'b1;
                        MEM_VALID <= 1'b0;
                        state     <= FINISH;
                    end else if (wait_cnt == 4'd15) begin
                        ERR       <= 1'b1;
                        DONE      <= 1'b1;
                        MEM_VALID <= 1'b0;
                        state     <= FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                FINISH: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    BUSY      <= 1'b0;
                    DONE      <= 1'b0;
                    MEM_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: expected completions go into a
// scoreboard queue when a request is driven and are checked at DONE.
module tb_mem_bus_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ;
    logic        WE;
    logic [7:0]  ADDR_H;
    logic [7:0]  ADDR_L;
    logic [7:0]  WDATA;
    logic [7:0]  MEM_DIN;
    logic        MEM_READY;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_DOUT;
    logic        MEM_RW;
    logic        MEM_VALID;
    logic [7:0]  RDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] dl_model;
    int         total = 0;
    int         bad = 0;

    mem_bus_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .WE        (WE),
        .ADDR_H    (ADDR_H),
        .ADDR_L    (ADDR_L),
        .WDATA     (WDATA),
        .MEM_DIN   (MEM_DIN),
        .MEM_READY (MEM_READY),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_DOUT  (MEM_DOUT),
        .MEM_RW    (MEM_RW),
        .MEM_VALID (MEM_VALID),
        .RDATA     (RDATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request for exactly one edge; returns #1 after the accepting edge.
    task automatic accept(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        @(negedge CLK);
        REQ       = 1'b1;
        WE        = we;
        ADDR_H    = addr[15:8];
        ADDR_L    = addr[7:0];
        WDATA     = wd;
        MEM_READY = 1'b0;
        @(posedge CLK);
        #1;
        REQ = 1'b0;
    endtask

    // Drive MEM_READY high only on ACCESS edge ready_edge (1-based, 0 = never),
    // stopping at DONE or after budget edges.
    task automatic run_wait(input int ready_edge, input logic [7:0] din, input int budget,
                            output int edges, output bit got);
        got   = 1'b0;
        edges = 0;
        while (!got && edges < budget) begin
            @(negedge CLK);
            MEM_READY = (edges + 1 == ready_edge);
            MEM_DIN   = din;
            @(posedge CLK);
            #1;
            edges++;
            if (DONE) got = 1'b1;
        end
        MEM_READY = 1'b0;
    endtask

    task automatic test_reset;
        logic [36:0] got, expv;
        RST = 1'b1; REQ = 1'b0; WE = 1'b0; ADDR_H = '0; ADDR_L = '0;
        WDATA = '0; MEM_DIN = '0; MEM_READY = 1'b0;
        dl_model = '0;
        repeat (2) begin @(posedge CLK); #1; end
        got  = {MEM_ADDR, MEM_DOUT, MEM_RW, MEM_VALID, RDATA, BUSY, DONE, ERR};
        expv = {16'h0000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", got, expv);
        end
        // MEM_READY in IDLE must not start anything.
        @(negedge CLK);
        RST = 1'b0;
        MEM_READY = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        total++;
        if ({BUSY, DONE, MEM_VALID} !== 3'b000) begin
            bad++;
            $display("FAIL ready_in_idle got=%b exp=000", {BUSY, DONE, MEM_VALID});
        end
        MEM_READY = 1'b0;
    endtask

    task automatic test_zero_wait_read;
        int edges; bit got; exp_t e;
        accept(1'b0, 16'h12F0, 8'h00);
        exp_q.push_back('{err: 1'b0, rdata: 8'hA5});
        dl_model = 8'hA5;
        total++;
        if ({MEM_ADDR, MEM_RW, MEM_VALID, BUSY} !== {16'h12F0, 1'b1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL read_issue got=%h/%b%b%b exp=12f0/111", MEM_ADDR, MEM_RW, MEM_VALID, BUSY);
        end
        run_wait(1, 8'hA5, 20, edges, got);
        total++;
        if (!got || edges != 1) begin
            bad++;
            $display("FAIL read_latency got=%0d/%0d exp=1/1", got, edges);
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL read_sb got=empty exp=entry");
        end else begin
            e = exp_q.pop_front();
            if ({ERR, RDATA, MEM_VALID} !== {e.err, e.rdata, 1'b0}) begin
                bad++;
                $display("FAIL read_result got=%b/%h/%b exp=%b/%h/0", ERR, RDATA, MEM_VALID, e.err, e.rdata);
            end
        end
        @(posedge CLK); #1;
        total++;
        if ({DONE, BUSY} !== 2'b00) begin
            bad++;
            $display("FAIL read_finish got=%b exp=00", {DONE, BUSY});
        end
    endtask

    task automatic test_write_wait;
        exp_t e;
        accept(1'b1, 16'h01FF, 8'h3C);
        exp_q.push_back('{err: 1'b0, rdata: dl_model});
        for (int i = 1; i <= 4; i++) begin
            total++;
            if ({MEM_RW, MEM_VALID, MEM_DOUT, MEM_ADDR, DONE} !== {1'b0, 1'b1, 8'h3C, 16'h01FF, 1'b0}) begin
                bad++;
                $display("FAIL write_stable cyc=%0d got=%b%b/%h/%h/%b exp=01/3c/01ff/0",
                         i, MEM_RW, MEM_VALID, MEM_DOUT, MEM_ADDR, DONE);
            end
            @(negedge CLK);
            MEM_READY = (i == 4);
            MEM_DIN   = 8'hFF;
            @(posedge CLK); #1;
        end
        MEM_READY = 1'b0;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL write_sb got=empty exp=entry");
        end else begin
            e = exp_q.pop_front();
            if ({DONE, ERR, RDATA} !== {1'b1, e.err, e.rdata}) begin
                bad++;
                $display("FAIL write_done got=%b/%b/%h exp=1/%b/%h", DONE, ERR, RDATA, e.err, e.rdata);
            end
        end
        @(posedge CLK); #1;
        total++;
        if ({MEM_VALID, MEM_ADDR, MEM_DOUT, BUSY} !== {1'b0, 16'h01FF, 8'h3C, 1'b0}) begin
            bad++;
            $display("FAIL write_hold got=%b/%h/%h/%b exp=0/01ff/3c/0", MEM_VALID, MEM_ADDR, MEM_DOUT, BUSY);
        end
    endtask

    task automatic test_timeout;
        int edges; bit got; exp_t e;
        accept(1'b0, 16'h4000, 8'h00);
        exp_q.push_back('{err: 1'b1, rdata: dl_model});
        run_wait(0, 8'hEE, 30, edges, got);
        total++;
        if (!got || edges != 16) begin
            bad++;
            $display("FAIL timeout_edges got=%0d/%0d exp=1/16", got, edges);
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL timeout_sb got=empty exp=entry");
        end else begin
            e = exp_q.pop_front();
            if ({ERR, RDATA} !== {e.err, e.rdata}) begin
                bad++;
                $display("FAIL timeout_result got=%b/%h exp=%b/%h", ERR, RDATA, e.err, e.rdata);
            end
        end
        @(posedge CLK); #1;
        total++;
        if ({ERR, DONE, BUSY} !== 3'b100) begin
            bad++;
            $display("FAIL timeout_err_hold got=%b exp=100", {ERR, DONE, BUSY});
        end
        accept(1'b0, 16'h4001, 8'h00);
        exp_q.push_back('{err: 1'b0, rdata: 8'h5A});
        dl_model = 8'h5A;
        total++;
        if (ERR !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err_clear got=%b exp=0", ERR);
        end
        run_wait(1, 8'h5A, 20, edges, got);
        total++;
        if (exp_q.size() == 0 || !got) begin
            bad++;
            $display("FAIL timeout_next got=%0d exp=1", got);
        end else begin
            e = exp_q.pop_front();
            if ({ERR, RDATA} !== {e.err, e.rdata}) begin
                bad++;
                $display("FAIL timeout_next_result got=%b/%h exp=%b/%h", ERR, RDATA, e.err, e.rdata);
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_boundary;
        int edges; bit got; exp_t e;
        accept(1'b0, 16'h8080, 8'h00);
        exp_q.push_back('{err: 1'b0, rdata: 8'hC3});
        dl_model = 8'hC3;
        run_wait(16, 8'hC3, 30, edges, got);
        total++;
        if (!got || edges != 16) begin
            bad++;
            $display("FAIL boundary_edges got=%0d/%0d exp=1/16", got, edges);
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL boundary_sb got=empty exp=entry");
        end else begin
            e = exp_q.pop_front();
            if ({ERR, RDATA} !== {e.err, e.rdata}) begin
                bad++;
                $display("FAIL boundary_result got=%b/%h exp=%b/%h", ERR, RDATA, e.err, e.rdata);
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back;
        int ph = 0;
        int dones = 0;
        logic [15:0] cap_addr = '0;
        exp_t e;
        for (int i = 1; i <= 9; i++) begin
            @(negedge CLK);
            ADDR_H    = 8'h20;
            ADDR_L    = 8'(i);
            MEM_DIN   = 8'h10 + 8'(i);
            WE        = 1'b0;
            MEM_READY = 1'b1;
            REQ       = (ph == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge CLK); #1;
            case (ph)
                0: begin cap_addr = {ADDR_H, ADDR_L}; ph = 1; end
                1: begin
                    dl_model = MEM_DIN;
                    exp_q.push_back('{err: 1'b0, rdata: MEM_DIN});
                    ph = 2;
                end
                default: ph = 0;
            endcase
            total++;
            if ({DONE, BUSY} !== {(ph == 2), (ph != 0)}) begin
                bad++;
                $display("FAIL b2b_phase cyc=%0d got=%b%b exp=%b%b", i, DONE, BUSY, (ph == 2), (ph != 0));
            end
            if (ph != 0) begin
                total++;
                if (MEM_ADDR !== cap_addr) begin
                    bad++;
                    $display("FAIL b2b_addr cyc=%0d got=%h exp=%h", i, MEM_ADDR, cap_addr);
                end
            end
            if (ph == 2) begin
                dones++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_sb got=empty exp=entry");
                end else begin
                    e = exp_q.pop_front();
                    if ({ERR, RDATA} !== {e.err, e.rdata}) begin
                        bad++;
                        $display("FAIL b2b_result cyc=%0d got=%b/%h exp=%b/%h", i, ERR, RDATA, e.err, e.rdata);
                    end
                end
            end
        end
        REQ = 1'b0;
        MEM_READY = 1'b0;
        total++;
        if (dones != 3) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=3", dones);
        end
    endtask

    task automatic test_reset_mid_access;
        int edges; bit got; exp_t e;
        accept(1'b0, 16'h5555, 8'h00);
        exp_q.push_back('{err: 1'b0, rdata: 8'h99});
        @(negedge CLK);
        MEM_READY = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        RST = 1'b1;
        MEM_READY = 1'b1;
        MEM_DIN = 8'h99;
        exp_q.delete();
        dl_model = 8'h00;
        #1;
        total++;
        if ({MEM_VALID, BUSY, DONE, ERR, RDATA} !== {4'b0000, dl_model}) begin
            bad++;
            $display("FAIL rst_mid_async got=%b%b%b%b/%h exp=0000/%h", MEM_VALID, BUSY, DONE, ERR, RDATA, dl_model);
        end
        @(posedge CLK); #1;
        total++;
        if ({DONE, BUSY} !== 2'b00) begin
            bad++;
            $display("FAIL rst_mid_nodone got=%b exp=00", {DONE, BUSY});
        end
        @(negedge CLK);
        RST = 1'b0;
        MEM_READY = 1'b0;
        accept(1'b0, 16'hBEEF, 8'h00);
        exp_q.push_back('{err: 1'b0, rdata: 8'h77});
        dl_model = 8'h77;
        total++;
        if ({BUSY, MEM_ADDR} !== {1'b1, 16'hBEEF}) begin
            bad++;
            $display("FAIL rst_first_req got=%b/%h exp=1/beef", BUSY, MEM_ADDR);
        end
        run_wait(1, 8'h77, 20, edges, got);
        total++;
        if (exp_q.size() == 0 || !got) begin
            bad++;
            $display("FAIL rst_after_txn got=%0d exp=1", got);
        end else begin
            e = exp_q.pop_front();
            if ({ERR, RDATA} !== {e.err, e.rdata}) begin
                bad++;
                $display("FAIL rst_after_result got=%b/%h exp=%b/%h", ERR, RDATA, e.err, e.rdata);
            end
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_timeout();
        test_boundary();
        test_back_to_back();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
